// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from a 1-cycle-latency FIFO into a 3-entry buffer and streams them out.
// Optional FRS_BEAT_CNT_EN adds a 16-bit accepted-beat counter on beat_cnt_o.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             empty_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             rd_error_i,
  output logic             rd_en_o,
  input  logic             flush_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             underflow_o
`ifdef FRS_BEAT_CNT_EN
  ,
  output logic [15:0]      beat_cnt_o
`endif
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [PTR_W-1:0] head_q, tail_q, occ_q;
  logic             inflight_q;
  logic             capture, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads are only issued when the buffer has room for everything already in flight.
  assign rd_en_o   = !rst_i && !flush_i && !empty_i &&
                     ((CNT_W'(occ_q) + CNT_W'(inflight_q)) < DEPTH_C);
  assign capture   = inflight_q && !flush_i;
  assign m_valid_o = (occ_q != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign m_data_o  = m_valid_o ? mem_q[head_q] : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      last_q      <= '0;
      underflow_o <= 1'b0;
    end else begin
      inflight_q <= rd_en_o;
      last_q     <= m_data_o;
      if (inflight_q && rd_error_i) begin
        underflow_o <= 1'b1;
      end
      if (flush_i) begin
        occ_q  <= '0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop) begin
          head_q <= ptr_inc(head_q);
        end
        if (capture) begin
          tail_q <= ptr_inc(tail_q);
        end
        case ({capture, pop})
          2'b10:   occ_q <= occ_q + PTR_W'(1);
          2'b01:   occ_q <= occ_q - PTR_W'(1);
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Data storage carries no reset; validity is tracked by occ_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) begin
      mem_q[tail_q] <= rdata_i;
    end
  end

`ifdef FRS_BEAT_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_o <= '0;
    end else if (pop) begin
      beat_cnt_o <= beat_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: behavioural FIFO in front, monitor on the stream side.
module tb_fifo_rd_stream;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       empty_i;
  logic [7:0] rdata_i = '0;
  logic       rd_error_i = 1'b0;
  logic       rd_en_o;
  logic       flush_i = 1'b0;
  logic       m_valid_o;
  logic       m_ready_i = 1'b1;
  logic [7:0] m_data_o;
  logic       underflow_o;
`ifdef FRS_BEAT_CNT_EN
  logic [15:0] beat_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:131071];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] exp_q [$];

  fifo_rd_stream #(.WIDTH(8), .BUF_DEPTH(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .empty_i    (empty_i),
    .rdata_i    (rdata_i),
    .rd_error_i (rd_error_i),
    .rd_en_o    (rd_en_o),
    .flush_i    (flush_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .underflow_o(underflow_o)
`ifdef FRS_BEAT_CNT_EN
    ,
    .beat_cnt_o (beat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  assign empty_i = (wr_ptr == rd_ptr);

  // Behavioural FIFO read port with one cycle of read latency.
  always @(posedge clk_i) begin
    if (rd_en_o && (wr_ptr != rd_ptr)) begin
      rdata_i <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input bit expected);
    mem[wr_ptr] = d;
    if (expected) exp_q.push_back(d);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o || wr_ptr != rd_ptr) && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    chk(nm, int'(n < bound), 1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the buffer bound.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("occ_plus_inflight_le3", int'((32'(dut.occ_q) + 32'(dut.inflight_q)) <= 32'd3), 1);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got %0h expected none", m_data_o);
        end else begin
          chk("beat_data", int'(m_data_o), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int lat;
    int cnt;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);

    // Reset held with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_rd_en", int'(rd_en_o), 0);
      chk("rst_valid", int'(m_valid_o), 0);
      chk("rst_underflow", int'(underflow_o), 0);
    end
    chk("rst_data", int'(m_data_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Streaming: latency and gapless burst
    lat = 0;
    while (lat < 10) begin
      @(negedge clk_i);
      if (m_valid_o) break;
      lat++;
    end
    chk("first_beat_latency", lat, 2);
    cnt = 0;
    while (m_valid_o && cnt < 40) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("burst_len", cnt, 16);
    wait_drain("stream_drain", 50);

    // Backpressure: only three reads while stalled
    @(posedge clk_i); #1;
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rd_en_o) cnt++;
      if (m_valid_o) chk("stall_data", int'(m_data_o), 'h20);
    end
    chk("stall_rd_pulses", cnt, 3);
    chk("stall_valid", int'(m_valid_o), 1);
    @(posedge clk_i); #1;
    m_ready_i = 1'b1;
    wait_drain("bp_drain", 50);
    chk("idle_valid", int'(m_valid_o), 0);
    chk("idle_data_hold", int'(m_data_o), 'h27);

    // Flush with occ=2 and one read in flight
    @(posedge clk_i); #1;
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b0);
    push_byte(8'h33, 1'b1);
    push_byte(8'h34, 1'b1);
    cnt = 0;
    while (cnt < 10) begin
      @(posedge clk_i); #1;
      if (!rd_en_o && m_valid_o) break;
      cnt++;
    end
    chk("flush_setup", cnt, 2);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_rd_en", int'(rd_en_o), 0);
    @(posedge clk_i); #1;
    flush_i   = 1'b0;
    m_ready_i = 1'b1;
    chk("flush_valid", int'(m_valid_o), 0);
    wait_drain("flush_drain", 50);

    // rd_error without a read in flight is ignored
    @(posedge clk_i); #1;
    rd_error_i = 1'b1;
    @(posedge clk_i); #1;
    rd_error_i = 1'b0;
    chk("err_no_inflight", int'(underflow_o), 0);

    // Underflow: rd_error during an in-flight read is sticky
    push_byte(8'h40, 1'b1);
    @(posedge clk_i); #1;
    chk("uf_inflight", int'(dut.inflight_q), 1);
    rd_error_i = 1'b1;
    @(posedge clk_i); #1;
    rd_error_i = 1'b0;
    chk("uf_set", int'(underflow_o), 1);
    wait_drain("uf_drain", 50);
    repeat (5) @(negedge clk_i);
    chk("uf_sticky", int'(underflow_o), 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("uf_cleared", int'(underflow_o), 0);
    chk("rst2_valid", int'(m_valid_o), 0);
    rst_i = 1'b0;

`ifdef FRS_BEAT_CNT_EN
    chk("cnt_reset", int'(beat_cnt_o), 0);
    for (int i = 0; i < 70000; i++) push_byte(8'(i), 1'b1);
    wait_drain("cnt_drain", 80000);
    chk("cnt_wrap", int'(beat_cnt_o), 4464);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
